bram_filter_sys: RTL and testbench
==================================

Name: bram_filter_sys

Overview:
- Frame-buffered disparity post-filter. Buffers one decimated frame of packed disparity/confidence words and one of matching grayscale pixels into two on-chip RAMs.
- Once both frames are complete, reads them back in raster order and applies a gray-guided, confidence-gated left-to-right hole fill.
- Emits the filtered disparity/confidence stream. Sits after block matching / downsampling, before display or output.

Parameters:
- dec_frame_w, 80, frame width in pixels.
- dec_frame_h, 160, frame height in lines.
- disp_bits, 5, disparity field width; the packed word is {conf[7:0], disp[disp_bits-1:0]}.
- conf_thresh, 16, minimum confidence for a pixel to be trusted.
- gray_thresh, 8, maximum absolute gray difference allowed for propagation.

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- disp_conf_in_data  in  16  bits [disp_bits+7:0] = {conf, disp}; upper bits ignored.
- disp_conf_in_valid  in  1  source valid.
- disp_conf_in_ready  out  1  accept; transfer when valid&&ready.
- gray_in_data  in  8  gray pixel, raster order.
- gray_in_valid  in  1  source valid.
- gray_in_ready  out  1  accept.
- out_ready  in  1  sink ready.
- out_valid  out  1  output valid.
- out_data  out  8  filtered disparity shifted left by (8-disp_bits), for display.
- out_disp_conf  out  disp_bits+8  filtered {conf, disp}.

Behaviour:
- N = dec_frame_w*dec_frame_h. Memories: disp_conf RAM N x (disp_bits+8) and gray RAM N x 8. Each RAM has its own write counter.
- State WRITE:
  - Each ready is high while its counter < N.
  - Each accepted beat writes RAM[cnt] and increments cnt.
  - The two streams are independent: they may arrive on different cycles or rates, and are paired by index.
  - When both counters == N, go to READ. Both readies are low from that cycle.
- State READ:
  - The read address issues 0..N-1, advancing when the output stage can accept (output empty or out_ready).
  - RAM read latency 1 cycle. The concatenated read word is {disp_conf, gray}, width disp_bits+16.
  - The filter stage registers its result; out_valid is asserted 2 cycles after the address is issued when not stalled.
  - Out_valid/out_data/out_disp_conf hold stable while out_valid && !out_ready.
- Filter, per pixel in raster order, with row state {last_disp, last_gray, have_last}:
  - have_last clears at column 0.
  - If conf >= conf_thresh: output the pixel unchanged and load last_disp=disp, last_gray=gray, have_last=1.
  - Else if have_last and |gray-last_gray| <= gray_thresh: output disp=last_disp with the original conf. Row state is unchanged.
  - Else output the pixel unchanged.
- After the last output beat (address N-1) is accepted: clear both counters and return to WRITE.
- Reset (async, low):
  - State WRITE, counters 0, out_valid 0, outputs 0.
  - Both readies go high the first cycle after deassertion.
  - Reset mid-frame discards the partial frame.
- Boundaries:
  - Input beats offered after a counter reaches N are not accepted.
  - Simultaneous final beats on both streams go to READ the next cycle.
  - Column wrap resets propagation; rows never propagate across.
  - Continuous out_ready=1 yields one output per cycle.

Decomposition:
- Package bram_filter_pkg: function for the packed-word width (disp_bits+8), field-extract helpers, state enum {WRITE, READ}.
- One natural sub-module: simple_dp_ram (1 write port, 1 registered read port, parameterised width/depth), instantiated twice.

Test Plan:
- Reset held low 100 ns, release -> both readies 1, out_valid 0; after N beats per stream, readies 0 and exactly N outputs follow in index order.
- All conf=200, disp=i%32 -> out_disp_conf equals input at every index; out_data = disp<<3.
- Row 0: px0 {conf 50, disp 7, gray 100}; px1 {conf 0, disp 2, gray 104} -> out px1 disp 7, conf 0. Same except px1 gray 120 -> disp 2 unchanged.
- Low-confidence pixel at column 0 following a trusted pixel at the previous row end -> output unchanged (no cross-row fill).
- Streams fed at half rate with gray leading disp_conf by 50 beats -> output identical to the lock-step case.
- out_ready toggled randomly -> no beat lost or duplicated, data stable while stalled; a second frame after the first is accepted correctly.

Source files
------------

// File: rtl/bram_filter_pkg.sv
// Shared types and helpers for the frame-buffered disparity post-filter.
package bram_filter_pkg;

   typedef enum logic {
      WRITE = 1'b0,
      READ  = 1'b1
   } state_e;

   // Width of the packed {conf, disp} word.
   function automatic int packed_width(input int disp_bits);
      return disp_bits + 8;
   endfunction

   // Confidence field of a packed {conf, disp} word.
   function automatic logic [7:0] get_conf(input logic [15:0] word, input int disp_bits);
      return 8'(word >> disp_bits);
   endfunction

   // Disparity field of a packed word, zero-extended to 8 bits.
   function automatic logic [7:0] get_disp(input logic [15:0] word, input int disp_bits);
      logic [15:0] mask;
      mask = 16'((32'd1 << disp_bits) - 32'd1);
      return 8'(word & mask);
   endfunction

   function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

endpackage

// File: rtl/simple_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
module simple_dp_ram #(
   parameter int width = 8,
   parameter int depth = 16,
   localparam int aw = (depth > 1) ? $clog2(depth) : 1
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [aw-1:0]    wr_addr,
   input  logic [width-1:0] wr_data,
   input  logic             rd_en,
   input  logic [aw-1:0]    rd_addr,
   output logic [width-1:0] rd_data
);

   logic [width-1:0] mem [depth];

   // Write on request; read data register holds while rd_en is low.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/bram_filter_sys.sv
// Frame-buffered disparity post-filter: buffers one frame of {conf, disp} and
// gray, then replays it in raster order through a gray-guided hole fill.
//
// state | meaning
// WRITE | accepting both input streams into the RAMs
// READ  | replaying the frame through the filter to the output
module bram_filter_sys
   import bram_filter_pkg::*;
#(
   parameter int dec_frame_w = 80,
   parameter int dec_frame_h = 160,
   parameter int disp_bits   = 5,
   parameter int conf_thresh = 16,
   parameter int gray_thresh = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [15:0]          disp_conf_in_data,
   input  logic                 disp_conf_in_valid,
   output logic                 disp_conf_in_ready,
   input  logic [7:0]           gray_in_data,
   input  logic                 gray_in_valid,
   output logic                 gray_in_ready,
   input  logic                 out_ready,
   output logic                 out_valid,
   output logic [7:0]           out_data,
   output logic [disp_bits+7:0] out_disp_conf
);

   localparam int pw = packed_width(disp_bits);
   localparam int n  = dec_frame_w * dec_frame_h;
   localparam int aw = (n > 1) ? $clog2(n) : 1;
   localparam int cw = $clog2(n + 1);

   state_e          state;
   logic [cw-1:0]   cnt_dc, cnt_gr, rd_cnt, col;
   logic [cw-1:0]   cnt_dc_nxt, cnt_gr_nxt;
   logic            acc_dc, acc_gr, dc_full_nxt, gr_full_nxt;
   logic            advance, issue, frame_done;
   logic            s1_valid, s1_last, out_last;
   logic [pw-1:0]   dc_wr_data, dc_rd;
   logic [7:0]      gr_rd;
   logic [pw+7:0]   rd_word;
   logic [pw-1:0]   pix_dc;
   logic [7:0]      pix_gray, pix_conf;
   logic [disp_bits-1:0] pix_disp, sel_disp, last_disp;
   logic [7:0]      last_gray;
   logic            have_last, trusted, fill;

   assign acc_dc      = disp_conf_in_valid && disp_conf_in_ready;
   assign acc_gr      = gray_in_valid && gray_in_ready;
   assign cnt_dc_nxt  = cnt_dc + cw'(acc_dc);
   assign cnt_gr_nxt  = cnt_gr + cw'(acc_gr);
   assign dc_full_nxt = (cnt_dc_nxt == cw'(n));
   assign gr_full_nxt = (cnt_gr_nxt == cw'(n));

   // The whole read pipeline moves together whenever the output register can take a new beat.
   assign advance    = !out_valid || out_ready;
   assign issue      = (state == READ) && (rd_cnt != cw'(n)) && advance;
   assign frame_done = out_valid && out_ready && out_last;

   assign dc_wr_data = {get_conf(disp_conf_in_data, disp_bits),
                        disp_bits'(get_disp(disp_conf_in_data, disp_bits))};

   simple_dp_ram #(.width(pw), .depth(n)) u_dc_ram (
      .clk     (clk),
      .wr_en   (acc_dc),
      .wr_addr (cnt_dc[aw-1:0]),
      .wr_data (dc_wr_data),
      .rd_en   (issue),
      .rd_addr (rd_cnt[aw-1:0]),
      .rd_data (dc_rd)
   );

   simple_dp_ram #(.width(8), .depth(n)) u_gray_ram (
      .clk     (clk),
      .wr_en   (acc_gr),
      .wr_addr (cnt_gr[aw-1:0]),
      .wr_data (gray_in_data),
      .rd_en   (issue),
      .rd_addr (rd_cnt[aw-1:0]),
      .rd_data (gr_rd)
   );

   assign rd_word  = {dc_rd, gr_rd};
   assign pix_dc   = rd_word[pw+7:8];
   assign pix_gray = rd_word[7:0];

   // Frame sequencing: write counters, registered readies, read address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state              <= WRITE;
         cnt_dc             <= '0;
         cnt_gr             <= '0;
         rd_cnt             <= '0;
         disp_conf_in_ready <= 1'b0;
         gray_in_ready      <= 1'b0;
      end else begin
         case (state)
            WRITE: begin
               cnt_dc <= cnt_dc_nxt;
               cnt_gr <= cnt_gr_nxt;
               if (dc_full_nxt && gr_full_nxt) begin
                  state              <= READ;
                  disp_conf_in_ready <= 1'b0;
                  gray_in_ready      <= 1'b0;
               end else begin
                  disp_conf_in_ready <= !dc_full_nxt;
                  gray_in_ready      <= !gr_full_nxt;
               end
            end
            READ: begin
               if (issue) rd_cnt <= rd_cnt + cw'(1);
               if (frame_done) begin
                  state              <= WRITE;
                  cnt_dc             <= '0;
                  cnt_gr             <= '0;
                  rd_cnt             <= '0;
                  disp_conf_in_ready <= 1'b1;
                  gray_in_ready      <= 1'b1;
               end
            end
            default: state <= WRITE;
         endcase
      end
   end

   // Valid/last tracking alongside the RAM read register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
      end else if (advance) begin
         s1_valid <= issue;
         s1_last  <= issue && (rd_cnt == cw'(n - 1));
      end
   end

   // Fill decision for the pixel currently at the RAM output.
   always_comb begin
      pix_conf = get_conf(16'(pix_dc), disp_bits);
      pix_disp = disp_bits'(get_disp(16'(pix_dc), disp_bits));
      trusted  = (pix_conf >= 8'(conf_thresh));
      fill     = !trusted && have_last && (col != '0)
                 && (abs_diff(pix_gray, last_gray) <= 8'(gray_thresh));
      sel_disp = fill ? last_disp : pix_disp;
   end

   // Output register and per-row propagation state; col==0 blocks fill across rows.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid     <= 1'b0;
         out_last      <= 1'b0;
         out_data      <= '0;
         out_disp_conf <= '0;
         last_disp     <= '0;
         last_gray     <= '0;
         have_last     <= 1'b0;
         col           <= '0;
      end else if (advance) begin
         out_valid <= s1_valid;
         out_last  <= s1_last;
         if (s1_valid) begin
            out_disp_conf <= {pix_conf, sel_disp};
            out_data      <= 8'(sel_disp) << (8 - disp_bits);
            col           <= (col == cw'(dec_frame_w - 1)) ? '0 : col + cw'(1);
            if (trusted) begin
               last_disp <= pix_disp;
               last_gray <= pix_gray;
               have_last <= 1'b1;
            end else if (col == '0) begin
               have_last <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_bram_filter_sys.sv
// Directed bench for bram_filter_sys using a scoreboard of expected output words.
module tb_bram_filter_sys;

   localparam int W  = 16;
   localparam int H  = 8;
   localparam int DB = 5;
   localparam int N  = W * H;
   localparam int PW = DB + 8;

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   disp_conf_in_data;
   logic          disp_conf_in_valid;
   logic          disp_conf_in_ready;
   logic [7:0]    gray_in_data;
   logic          gray_in_valid;
   logic          gray_in_ready;
   logic          out_ready;
   logic          out_valid;
   logic [7:0]    out_data;
   logic [PW-1:0] out_disp_conf;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]    in_conf [N];
   logic [DB-1:0] in_disp [N];
   logic [7:0]    in_gray [N];
   logic [PW-1:0] exp_w   [N];
   logic [PW-1:0] got_w   [N];
   logic [PW-1:0] saved_w [N];
   logic [PW-1:0] sb [$];

   always #5 clk = ~clk;

   bram_filter_sys #(
      .dec_frame_w (W),
      .dec_frame_h (H),
      .disp_bits   (DB),
      .conf_thresh (16),
      .gray_thresh (8)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .disp_conf_in_data  (disp_conf_in_data),
      .disp_conf_in_valid (disp_conf_in_valid),
      .disp_conf_in_ready (disp_conf_in_ready),
      .gray_in_data       (gray_in_data),
      .gray_in_valid      (gray_in_valid),
      .gray_in_ready      (gray_in_ready),
      .out_ready          (out_ready),
      .out_valid          (out_valid),
      .out_data           (out_data),
      .out_disp_conf      (out_disp_conf)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Reference hole fill over the whole frame, row by row.
   task automatic build_model();
      logic [DB-1:0] ld;
      logic [7:0]    lg, d;
      bit            have;
      int            i;
      for (int r = 0; r < H; r++) begin
         have = 0;
         ld   = '0;
         lg   = '0;
         for (int c = 0; c < W; c++) begin
            i = r * W + c;
            d = (in_gray[i] > lg) ? in_gray[i] - lg : lg - in_gray[i];
            if (in_conf[i] >= 8'd16) begin
               exp_w[i] = {in_conf[i], in_disp[i]};
               ld = in_disp[i];
               lg = in_gray[i];
               have = 1;
            end else if (have && d <= 8'd8) begin
               exp_w[i] = {in_conf[i], ld};
            end else begin
               exp_w[i] = {in_conf[i], in_disp[i]};
            end
         end
      end
   endtask

   task automatic rand_frame();
      for (int i = 0; i < N; i++) begin
         in_conf[i] = ($urandom_range(0, 3) == 0) ? 8'd200 : 8'($urandom_range(0, 30));
         in_disp[i] = DB'($urandom_range(0, 31));
         in_gray[i] = 8'($urandom_range(90, 120));
      end
   endtask

   // Feed both streams; gray may lead by 'lead' beats, optionally at half rate.
   task automatic feed(input bit half, input int lead);
      int gi = 0;
      int di = 0;
      int cyc = 0;
      bit gv, dv, checked = 0;
      build_model();
      while ((gi < N || di < N) && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (gi == N && di < N && !checked) begin
            chk("gray_ready_after_full", gray_in_ready, 0);
            checked = 1;
         end
         gv = (gi < N) && (!half || cyc % 2 == 0);
         dv = (di < N) && (gi >= lead) && (!half || cyc % 2 == 0);
         gray_in_valid      = gv || (gi >= N);
         gray_in_data       = gv ? in_gray[gi] : 8'hFF;
         disp_conf_in_valid = dv;
         disp_conf_in_data  = dv ? {3'b000, in_conf[di], in_disp[di]} : 16'hFFFF;
         if (gv && gray_in_ready) begin
            gi++;
            if (gi <= di) sb.push_back(exp_w[gi-1]);
         end
         if (dv && disp_conf_in_ready) begin
            di++;
            if (di <= gi) sb.push_back(exp_w[di-1]);
         end
      end
      chk("feed_complete", (gi == N) && (di == N), 1);
      @(negedge clk);
      gray_in_valid      = 1'b0;
      disp_conf_in_valid = 1'b0;
      chk("dc_ready_low_in_read", disp_conf_in_ready, 0);
      chk("gray_ready_low_in_read", gray_in_ready, 0);
   endtask

   // Drain one frame, checking order, values and stability under back-pressure.
   task automatic collect(input bit rnd);
      int cnt = 0;
      int cyc = 0;
      bit stalled = 0;
      bit r;
      logic [PW-1:0] pd, e;
      logic [7:0]    pdat;
      while (cnt < N && cyc < 5000) begin
         @(negedge clk);
         cyc++;
         if (stalled) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_disp_conf", out_disp_conf, pd);
            chk("stall_data", out_data, pdat);
         end
         r = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         out_ready = r;
         if (out_valid && r) begin
            chk("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("out_disp_conf", out_disp_conf, e);
               chk("out_data", out_data, {e[DB-1:0], 3'b000});
            end
            got_w[cnt] = out_disp_conf;
            cnt++;
         end
         stalled = out_valid && !r;
         pd      = out_disp_conf;
         pdat    = out_data;
      end
      chk("collect_count", cnt, N);
      @(negedge clk);
      out_ready = 1'b1;
      chk("idle_out_valid", out_valid, 0);
      chk("dc_ready_rearmed", disp_conf_in_ready, 1);
      chk("gray_ready_rearmed", gray_in_ready, 1);
      chk("sb_empty", sb.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset              = 1'b0;
      disp_conf_in_valid = 1'b0;
      disp_conf_in_data  = '0;
      gray_in_valid      = 1'b0;
      gray_in_data       = '0;
      out_ready          = 1'b1;

      #50;
      chk("rst_dc_ready", disp_conf_in_ready, 0);
      chk("rst_gray_ready", gray_in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_disp_conf", out_disp_conf, 0);
      #50;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("release_dc_ready", disp_conf_in_ready, 0);
      @(negedge clk);
      chk("post_rst_dc_ready", disp_conf_in_ready, 1);
      chk("post_rst_gray_ready", gray_in_ready, 1);
      chk("post_rst_out_valid", out_valid, 0);

      // Frame 1: all trusted, output equals input.
      for (int i = 0; i < N; i++) begin
         in_conf[i] = 8'd200;
         in_disp[i] = DB'(i % 32);
         in_gray[i] = 8'($urandom_range(0, 255));
      end
      feed(0, 0);
      collect(0);
      chk("f1_px37", got_w[37], {8'd200, 5'd5});
      chk("f1_px127", got_w[127], {8'd200, 5'd31});

      // Frame 2: directed fill / no-fill / row-boundary pixels.
      rand_frame();
      in_conf[0]  = 8'd50; in_disp[0]  = 5'd7; in_gray[0]  = 8'd100;
      in_conf[1]  = 8'd0;  in_disp[1]  = 5'd2; in_gray[1]  = 8'd104;
      in_conf[15] = 8'd200; in_disp[15] = 5'd9; in_gray[15] = 8'd60;
      in_conf[16] = 8'd0;  in_disp[16] = 5'd3; in_gray[16] = 8'd62;
      in_conf[32] = 8'd50; in_disp[32] = 5'd7; in_gray[32] = 8'd100;
      in_conf[33] = 8'd0;  in_disp[33] = 5'd2; in_gray[33] = 8'd120;
      feed(0, 0);
      collect(0);
      chk("fill_px1", got_w[1], {8'd0, 5'd7});
      chk("row_wrap_px16", got_w[16], {8'd0, 5'd3});
      chk("gray_far_px33", got_w[33], {8'd0, 5'd2});
      for (int i = 0; i < N; i++) saved_w[i] = got_w[i];

      // Frame 3: same data at half rate with gray leading by 50 beats.
      feed(1, 50);
      collect(0);
      for (int i = 0; i < N; i++) chk("halfrate_vs_lockstep", got_w[i], saved_w[i]);

      // Frames 4 and 5: random data with random back-pressure.
      rand_frame();
      feed(0, 0);
      collect(1);
      rand_frame();
      feed(0, 0);
      collect(1);

      // Reset mid-frame discards the partial frame.
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         disp_conf_in_valid = 1'b1;
         disp_conf_in_data  = 16'h1FFF;
         gray_in_valid      = 1'b1;
         gray_in_data       = 8'hAA;
      end
      @(negedge clk);
      disp_conf_in_valid = 1'b0;
      gray_in_valid      = 1'b0;
      reset = 1'b0;
      #1;
      chk("midrst_dc_ready", disp_conf_in_ready, 0);
      chk("midrst_out_valid", out_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_rearm", disp_conf_in_ready, 1);
      sb.delete();
      rand_frame();
      feed(0, 0);
      collect(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
